// File: rtl/uart_reg_bank.sv
// Command-driven register bank: decodes UART write/read bursts into NUM_REGS byte registers.
// Writes land one clock after the data byte; read-back streams over valid/ready and holds while not ready.
module uart_reg_bank #(
    parameter int                      NUM_REGS     = 8,
    parameter logic [NUM_REGS*8-1:0]   RESET_VALUES = '0,
    parameter int                      TIMEOUT_CLKS = 2840
) (
    input  logic                    clk_in,
    input  logic                    rst_in_n,
    input  logic                    rx_dv_in,
    input  logic [7:0]              rx_data_in,
    output logic                    tx_valid_out,
    output logic [7:0]              tx_data_out,
    input  logic                    tx_ready_in,
    output logic [NUM_REGS*8-1:0]   regs_out,
    output logic [NUM_REGS-1:0]     wr_strobe_out,
    output logic                    busy_out,
    output logic                    timeout_out
);

    localparam int IW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              ptr_q, ptr_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [IW-1:0]           idle_q, idle_d;
    logic [NUM_REGS*8-1:0]   regs_q, regs_d;
    logic [NUM_REGS-1:0]     strobe_q, strobe_d;
    logic                    timeout_q, timeout_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [7:0]              tx_data_q, tx_data_d;

    // Addresses beyond the implemented registers read back as zero.
    function automatic logic [7:0] rd_byte(input logic [3:0] addr,
                                           input logic [NUM_REGS*8-1:0] img);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr == 4'(k)) r = img[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        regs_d     = regs_q;
        strobe_d   = '0;
        timeout_d  = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: begin
                idle_d     = '0;
                tx_valid_d = 1'b0;
                if (rx_dv_in) begin
                    ptr_d = rx_data_in[3:0];
                    cnt_d = rx_data_in[6:4];
                    if (rx_data_in[7]) begin
                        state_d    = RDATA;
                        tx_valid_d = 1'b1;
                        tx_data_d  = rd_byte(rx_data_in[3:0], regs_q);
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                // A byte on the expiry cycle wins over the timeout.
                if (rx_dv_in) begin
                    idle_d = '0;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (ptr_q == 4'(k)) begin
                            regs_d[8*k +: 8] = rx_data_in;
                            strobe_d[k]      = 1'b1;
                        end
                    end
                    ptr_d = ptr_q + 4'd1;
                    if (cnt_q == 3'd0) state_d = IDLE;
                    else               cnt_d   = cnt_q - 3'd1;
                end else if (idle_q == IW'(TIMEOUT_CLKS - 1)) begin
                    timeout_d = 1'b1;
                    idle_d    = '0;
                    state_d   = IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            RDATA: begin
                if (tx_valid_q && tx_ready_in) begin
                    ptr_d = ptr_q + 4'd1;
                    if (cnt_q == 3'd0) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end else begin
                        cnt_d     = cnt_q - 3'd1;
                        tx_data_d = rd_byte(ptr_q + 4'd1, regs_q);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                idle_d     = '0;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            idle_q     <= '0;
            regs_q     <= RESET_VALUES;
            strobe_q   <= '0;
            timeout_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            regs_q     <= regs_d;
            strobe_q   <= strobe_d;
            timeout_q  <= timeout_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign regs_out      = regs_q;
    assign wr_strobe_out = strobe_q;
    assign timeout_out   = timeout_q;
    assign tx_valid_out  = tx_valid_q;
    assign tx_data_out   = tx_data_q;
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_reg_bank.sv
// Scoreboard bench for uart_reg_bank: a register-image model predicts writes, reads and timeouts.
module tb_uart_reg_bank;

    localparam int          NR   = 8;
    localparam int          TO   = 2840;
    localparam logic [63:0] RSTV = 64'h7766_5544_3322_1106;

    logic          clk_in = 1'b0;
    logic          rst_in_n = 1'b0;
    logic          rx_dv_in = 1'b0;
    logic [7:0]    rx_data_in = 8'h00;
    logic          tx_valid_out;
    logic [7:0]    tx_data_out;
    logic          tx_ready_in = 1'b0;
    logic [63:0]   regs_out;
    logic [NR-1:0] wr_strobe_out;
    logic          busy_out;
    logic          timeout_out;

    uart_reg_bank #(.NUM_REGS(NR), .RESET_VALUES(RSTV), .TIMEOUT_CLKS(TO)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n),
        .rx_dv_in(rx_dv_in), .rx_data_in(rx_data_in),
        .tx_valid_out(tx_valid_out), .tx_data_out(tx_data_out), .tx_ready_in(tx_ready_in),
        .regs_out(regs_out), .wr_strobe_out(wr_strobe_out),
        .busy_out(busy_out), .timeout_out(timeout_out)
    );

    initial forever #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ref_regs [16];
    logic [11:0] wr_q [$];
    logic [7:0]  rd_q [$];
    int          exp_to = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) ref_regs[i] = (i < NR) ? RSTV[8*i +: 8] : 8'h00;
    endfunction

    function automatic void model_write(input int a, input logic [7:0] d);
        if (a < NR) begin
            ref_regs[a] = d;
            wr_q.push_back({4'(a), d});
        end
    endfunction

    function automatic logic [63:0] model_image();
        logic [63:0] img;
        for (int i = 0; i < NR; i++) img[8*i +: 8] = ref_regs[i];
        return img;
    endfunction

    // ---------------- monitor ----------------
    logic       prev_vld = 1'b0, prev_rdy = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    always @(negedge clk_in) begin
        if (!rst_in_n) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (wr_strobe_out != '0) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_strobe", {56'h0, wr_strobe_out}, 64'h0);
                end else begin
                    logic [11:0] e;
                    e = wr_q.pop_front();
                    chk("wr_strobe", {56'h0, wr_strobe_out}, 64'(1) << e[11:8]);
                    chk("wr_data", {56'h0, regs_out[8*e[11:8] +: 8]}, {56'h0, e[7:0]});
                end
            end
            if (prev_vld && !prev_rdy) begin
                chk("tx_hold_vld", {63'h0, tx_valid_out}, 64'h1);
                chk("tx_hold_dat", {56'h0, tx_data_out}, {56'h0, prev_dat});
            end
            if (tx_valid_out && tx_ready_in) begin
                if (rd_q.size() == 0) chk("unexpected_tx", {56'h0, tx_data_out}, 64'hFFFF);
                else                  chk("tx_data", {56'h0, tx_data_out}, {56'h0, rd_q.pop_front()});
            end
            if (timeout_out) begin
                chk("timeout_expected", {63'h0, exp_to > 0}, 64'h1);
                if (exp_to > 0) exp_to--;
            end
            prev_vld = tx_valid_out;
            prev_rdy = tx_ready_in;
            prev_dat = tx_data_out;
        end
    end

    // Transmitter readiness is random every cycle.
    initial forever begin
        @(posedge clk_in);
        #1;
        tx_ready_in = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv_in   = 1'b1;
        rx_data_in = b;
        @(posedge clk_in);
        #1;
        rx_dv_in   = 1'b0;
    endtask

    task automatic wr(input int addr, input int len, input logic [63:0] dat, input int gap);
        send_byte({1'b0, 3'(len - 1), 4'(addr)});
        for (int i = 0; i < len; i++) begin
            idle(gap < 0 ? $urandom_range(0, 3) : gap);
            model_write((addr + i) % 16, dat[8*i +: 8]);
            send_byte(dat[8*i +: 8]);
        end
        chk("busy_after_wr", {63'h0, busy_out}, 64'h0);
    endtask

    task automatic rd(input int addr, input int len);
        int n;
        for (int i = 0; i < len; i++) rd_q.push_back(ref_regs[(addr + i) % 16]);
        send_byte({1'b1, 3'(len - 1), 4'(addr)});
        send_byte(8'($urandom));
        n = 0;
        while (rd_q.size() > 0 && n < 300) begin
            idle(1);
            n++;
        end
        if (rd_q.size() > 0) begin
            chk("rd_drain_timeout", 64'(rd_q.size()), 64'h0);
            rd_q.delete();
        end
        chk("busy_after_rd", {63'h0, busy_out}, 64'h0);
    endtask

    initial begin
        model_reset();
        idle(3);
        chk("rst_regs", regs_out, RSTV);
        chk("rst_busy", {63'h0, busy_out}, 64'h0);
        chk("rst_tx_vld", {63'h0, tx_valid_out}, 64'h0);
        chk("rst_tx_dat", {56'h0, tx_data_out}, 64'h0);
        chk("rst_strobe", {56'h0, wr_strobe_out}, 64'h0);
        chk("rst_timeout", {63'h0, timeout_out}, 64'h0);
        rst_in_n = 1'b1;
        idle(2);

        wr(2, 1, 64'hA5, 0);
        wr(3, 4, 64'h4433_2211, -1);
        rd(3, 2);

        // Partial burst then silence: timeout after TO idle cycles.
        send_byte(8'h21);
        model_write(1, 8'h5A);
        send_byte(8'h5A);
        exp_to++;
        idle(TO - 1);
        chk("pre_expiry_busy", {63'h0, busy_out}, 64'h1);
        chk("pre_expiry_to", {63'h0, timeout_out}, 64'h0);
        idle(1);
        chk("expiry_to", {63'h0, timeout_out}, 64'h1);
        chk("expiry_busy", {63'h0, busy_out}, 64'h0);
        idle(2);
        chk("to_consumed", 64'(exp_to), 64'h0);
        wr(5, 1, 64'hC3, 0);

        rd(14, 2);
        wr(15, 1, 64'hFF, 0);
        wr(6, 4, 64'hDDCC_BBAA, -1);
        // Byte landing exactly on the expiry cycle is accepted.
        wr(0, 2, 64'h9E_7C, TO - 1);

        for (int t = 0; t < 40; t++) begin
            int a, l;
            a = $urandom_range(0, 15);
            l = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 1) rd(a, l);
            else wr(a, l, {$urandom, $urandom}, -1);
        end
        chk("regs_mid", regs_out, model_image());

        // Reset in the middle of a burst.
        send_byte(8'h30);
        model_write(0, 8'h12);
        send_byte(8'h12);
        model_write(1, 8'h34);
        send_byte(8'h34);
        idle(1);
        rst_in_n = 1'b0;
        #2;
        model_reset();
        chk("midrst_regs", regs_out, RSTV);
        chk("midrst_busy", {63'h0, busy_out}, 64'h0);
        idle(2);
        rst_in_n = 1'b1;
        idle(1);
        wr(4, 2, 64'h6655, -1);
        rd(3, 3);

        idle(5);
        chk("wr_q_empty", 64'(wr_q.size()), 64'h0);
        chk("to_none_pending", 64'(exp_to), 64'h0);
        chk("regs_final", regs_out, model_image());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_reg_bank.md
# uart_reg_bank

Parametrised UART-facing register bank for the GPS signal generator. It accepts a byte stream from the existing `uart_rx` receiver and decodes single or burst write commands with auto-increment into `NUM_REGS` 8-bit configuration registers. It also answers read commands by streaming register contents to a UART transmitter through a valid/ready handshake. An inter-byte timeout aborts incomplete bursts, so a lost byte cannot desynchronise the command parser.

## Interface
Parameters:
- `NUM_REGS`, 8: number of 8-bit registers, legal range 2..16.
- `RESET_VALUES`, `{NUM_REGS{8'h00}}`: `NUM_REGS*8`-bit reset image; register k resets to bits `[8k+7:8k]`.
- `TIMEOUT_CLKS`, 2840: idle clocks tolerated between data bytes of a write burst. This is two byte-times at 142 clocks/bit.

Ports:
- `clk_in`  in  1  system clock (16.368 MHz).
- `rst_in_n`  in  1  asynchronous, active-low reset.
- `rx_dv_in`  in  1  one-cycle strobe: `rx_data_in` holds a received byte.
- `rx_data_in`  in  8  received byte.
- `tx_valid_out`  out  1  `tx_data_out` holds a read-back byte.
- `tx_data_out`  out  8  read-back byte.
- `tx_ready_in`  in  1  transmitter accepts the byte when high together with `tx_valid_out`.
- `regs_out`  out  `NUM_REGS*8`  flat register image; register k is at `[8k+7:8k]`.
- `wr_strobe_out`  out  `NUM_REGS`  one-hot, one-cycle pulse marking the register just written.
- `busy_out`  out  1  high whenever the state is not IDLE.
- `timeout_out`  out  1  one-cycle pulse when a burst is aborted by timeout.

## Operation
- Command byte fields:
  - bit 7: 1 = read, 0 = write.
  - bits [6:4]: burst length minus 1, giving 1..8 bytes.
  - bits [3:0]: start address.
- State IDLE:
  - On `rx_dv_in`, latch address pointer `ptr` = cmd[3:0] and remaining count `cnt` = cmd[6:4].
  - Go to WDATA (write command) or RDATA (read command).
- State WDATA:
  - On each `rx_dv_in`, write `rx_data_in` to register `ptr` and pulse `wr_strobe_out[ptr]`.
  - Then `ptr` = `ptr+1` mod 16.
  - If `cnt` = 0, go to IDLE; otherwise `cnt` = `cnt-1`.
  - An idle counter clears on every `rx_dv_in`. When it reaches `TIMEOUT_CLKS`, pulse `timeout_out` and go to IDLE. Registers already written keep their new values.
- State RDATA:
  - `tx_valid_out` = 1 and `tx_data_out` = register `ptr`.
  - On each handshake (`tx_valid_out` and `tx_ready_in`): `ptr` = `ptr+1` mod 16. If `cnt` = 0, go to IDLE; otherwise `cnt` = `cnt-1`.
  - `rx_dv_in` is ignored in RDATA; bytes received there are dropped.
- Addresses ≥ `NUM_REGS`: writes are dropped with no strobe, but still consume a byte and advance `ptr`. Reads return 8'h00.
- Illegal or unreachable state encodings recover to IDLE.

## Timing
- Reset values:
  - `regs_out` = `RESET_VALUES`.
  - `tx_valid_out` = 0, `tx_data_out` = 8'h00.
  - `wr_strobe_out` = 0, `busy_out` = 0, `timeout_out` = 0.
  - State = IDLE, `ptr` = 0, `cnt` = 0, idle counter = 0.
- Write latency: a data byte sampled with `rx_dv_in` at edge N is visible on `regs_out` after edge N. `wr_strobe_out` is high for exactly the cycle after edge N.
- Read latency:
  - Command sampled at edge N → `tx_valid_out` = 1 with valid data after edge N.
  - Next byte appears on the cycle after each handshake.
  - `tx_valid_out` and `tx_data_out` hold stable while `tx_ready_in` = 0.
  - The final handshake drops `tx_valid_out` on the next cycle.
- `busy_out` rises the cycle after the command byte and falls the cycle after the last byte or the timeout.
- Timeout: with no `rx_dv_in` for `TIMEOUT_CLKS` consecutive cycles in WDATA, `timeout_out` pulses and state returns to IDLE. A byte arriving on the expiry cycle is accepted as data and the timeout is cancelled.
- Wrap-around: with `NUM_REGS` = 8, a 4-byte write from address 6 writes registers 6 and 7, drops addresses 8 and 9, and consumes 4 bytes.
- Reset asserted mid-burst immediately restores all reset values; a partial burst is not resumed.

## Test plan
- Reset → `regs_out` = `RESET_VALUES` (use 64'h...06 for register 0), `busy_out` = 0, `tx_valid_out` = 0.
- Command 8'h02 then 8'hA5 → register 2 = 8'hA5, `wr_strobe_out` = 8'b0000_0100 for one cycle, `busy_out` returns to 0.
- Burst write: command 8'h33 then 8'h11, 8'h22, 8'h33, 8'h44 → registers 3..6 = 11/22/33/44, four strobes in address order.
- Read command 8'h93 with `tx_ready_in` toggling 1-0-1 → output sequence 8'h11, 8'h22 with data stable while not ready; state returns to IDLE after the 2nd handshake.
- Command 8'h21, one data byte, then silence for 2840 clocks → register 1 updated, `timeout_out` pulses once, state returns to IDLE. The next byte 8'h05 is parsed as a command.
- Read command 8'h9E (register 14 then 15) with `NUM_REGS` = 8 → returns 8'h00, 8'h00; write command 8'h0F followed by 8'hFF → no strobe and no register change.
